// File: rtl/fft4_sequencer_if.sv
// fft4_sequencer_if: control, sample-RAM and twiddle-ROM signals of the radix-4 FFT sequencer.
// master = sequencer side, slave = memory/host side.
interface fft4_sequencer_if #(
  parameter int FULL_WIDTH = 32,
  parameter int AW         = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [FULL_WIDTH-1:0] rd_data;
  logic [AW-1:0]         tw_addr;
  logic [FULL_WIDTH-1:0] tw_data;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [FULL_WIDTH-1:0] wr_data;

  modport master (
    input  start, rd_data, tw_data,
    output busy, done, rd_en, rd_addr, tw_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, tw_data,
    input  busy, done, rd_en, rd_addr, tw_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/fft4_sequencer.sv
// fft4_sequencer: in-place radix-4 DIT FFT over an external sample RAM and twiddle ROM.
// Define FFT_SCALE_EN to shift every butterfly result right by 2 (total 1/N) before writeback.

module butterfly_4 #(
  parameter int FULL_WIDTH = 32
) (
  input  logic [3:0][FULL_WIDTH-1:0] x,
  input  logic [3:0][FULL_WIDTH-1:0] w,
  output logic [3:0][FULL_WIDTH-1:0] y
);
  localparam int HW = FULL_WIDTH / 2;

  logic [3:0][HW-1:0] mr, mi;

  // Each product keeps bits [2HW-2:HW-1]; truncation happens per product, before the sum.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mul
    logic signed [HW-1:0]         xr, xi, wr, wi;
    logic signed [FULL_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
    assign xr   = x[gi][FULL_WIDTH-1:HW];
    assign xi   = x[gi][HW-1:0];
    assign wr   = w[gi][FULL_WIDTH-1:HW];
    assign wi   = w[gi][HW-1:0];
    assign p_rr = xr * wr;
    assign p_ii = xi * wi;
    assign p_ri = xr * wi;
    assign p_ir = xi * wr;
    assign mr[gi] = HW'((p_rr >>> (HW - 1)) - (p_ii >>> (HW - 1)));
    assign mi[gi] = HW'((p_ri >>> (HW - 1)) + (p_ir >>> (HW - 1)));
  end

  // Forward DFT-4: y_m = sum_n x_n * (-j)^(n*m), all sums wrap modulo 2^HW.
  assign y[0] = {mr[0] + mr[1] + mr[2] + mr[3], mi[0] + mi[1] + mi[2] + mi[3]};
  assign y[1] = {mr[0] + mi[1] - mr[2] - mi[3], mi[0] - mr[1] - mi[2] + mr[3]};
  assign y[2] = {mr[0] - mr[1] + mr[2] - mr[3], mi[0] - mi[1] + mi[2] - mi[3]};
  assign y[3] = {mr[0] - mi[1] - mr[2] + mi[3], mi[0] + mr[1] - mi[2] - mr[3]};
endmodule

module fft4_sequencer #(
  parameter int FULL_WIDTH = 32,
  parameter int LOG4_N     = 2
) (
  input  logic             clk,
  input  logic             rst,
  fft4_sequencer_if.master bus
);
  localparam int AW = 2 * LOG4_N;
  localparam int HW = FULL_WIDTH / 2;

  typedef enum logic [2:0] {IDLE, RD, RDW, BF, WR, DONE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      k_reg, k_next;
  logic [AW-1:0]   s_reg, s_next, g_reg, g_next, j_reg, j_next;
  logic [AW:0]     lsh_cur, lsh_nxt;
  logic            last_j, last_g, last_s;
  logic [AW-1:0]   addr_c, tw_c;

  logic [3:0][FULL_WIDTH-1:0] opnd_reg, tw_reg, res_reg, bf_y, res_in;

  logic                  busy_reg, busy_next, done_reg, done_next;
  logic                  rd_en_reg, rd_en_next, wr_en_reg, wr_en_next;
  logic [AW-1:0]         rd_addr_reg, rd_addr_next, tw_addr_reg, tw_addr_next;
  logic [AW-1:0]         wr_addr_reg, wr_addr_next;
  logic [FULL_WIDTH-1:0] wr_data_reg, wr_data_next;

  // log2(L) = 2s; L-1 and N/(4L)-1 come from shifting an all-ones mask.
  assign lsh_cur = {s_reg, 1'b0};
  assign lsh_nxt = {s_next, 1'b0};
  assign last_j  = (j_reg == ~({AW{1'b1}} << lsh_cur));
  assign last_g  = (g_reg == ({AW{1'b1}} >> (lsh_cur + (AW+1)'(2))));
  assign last_s  = (s_reg == AW'(LOG4_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      s_reg     <= '0;
      g_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      s_reg     <= s_next;
      g_reg     <= g_next;
      j_reg     <= j_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    s_next     = s_reg;
    g_next     = g_reg;
    j_next     = j_reg;
    case (state_reg)
      IDLE: if (bus.start) begin
        state_next = RD;
        k_next     = '0;
        s_next     = '0;
        g_next     = '0;
        j_next     = '0;
      end
      RD: begin
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) state_next = RDW;
      end
      RDW:  state_next = BF;
      BF:   state_next = WR;
      WR: begin
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) begin
          state_next = RD;
          if (!last_j) begin
            j_next = j_reg + AW'(1);
          end else begin
            j_next = '0;
            if (!last_g) begin
              g_next = g_reg + AW'(1);
            end else begin
              g_next = '0;
              if (last_s) begin
                s_next     = '0;
                state_next = DONE;
              end else begin
                s_next = s_reg + AW'(1);
              end
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without extra latency.
  always_comb begin
    addr_c       = (g_next << (lsh_nxt + (AW+1)'(2))) + j_next + (AW'(k_next) << lsh_nxt);
    tw_c         = (j_next * AW'(k_next)) << ((AW+1)'(AW - 2) - lsh_nxt);
    busy_next    = (state_next == RD) || (state_next == RDW) || (state_next == BF) || (state_next == WR);
    done_next    = (state_next == DONE);
    rd_en_next   = (state_next == RD);
    wr_en_next   = (state_next == WR);
    rd_addr_next = rd_en_next ? addr_c : '0;
    tw_addr_next = rd_en_next ? tw_c : '0;
    wr_addr_next = wr_en_next ? addr_c : '0;
    wr_data_next = '0;
    if (wr_en_next) begin
      // r0 is still being loaded on the BF->WR edge, so take it straight from the butterfly.
      wr_data_next = (state_reg == BF) ? res_in[0] : res_reg[k_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rd_en_reg   <= 1'b0;
      wr_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      tw_addr_reg <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      rd_en_reg   <= rd_en_next;
      wr_en_reg   <= wr_en_next;
      rd_addr_reg <= rd_addr_next;
      tw_addr_reg <= tw_addr_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Read data lags the strobe by one cycle: RD k captures operand k-1, RDW captures operand 3.
  always_ff @(posedge clk) begin
    if (state_reg == RD && k_reg != 2'd0) begin
      opnd_reg[k_reg - 2'd1] <= bus.rd_data;
      tw_reg[k_reg - 2'd1]   <= bus.tw_data;
    end
    if (state_reg == RDW) begin
      opnd_reg[3] <= bus.rd_data;
      tw_reg[3]   <= bus.tw_data;
    end
    if (state_reg == BF) res_reg <= res_in;
  end

  butterfly_4 #(.FULL_WIDTH(FULL_WIDTH)) u_bf (
    .x (opnd_reg),
    .w (tw_reg),
    .y (bf_y)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_scale
`ifdef FFT_SCALE_EN
    assign res_in[gi] = {HW'($signed(bf_y[gi][FULL_WIDTH-1:HW]) >>> 2),
                         HW'($signed(bf_y[gi][HW-1:0]) >>> 2)};
`else
    assign res_in[gi] = bf_y[gi];
`endif
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.rd_en   = rd_en_reg;
  assign bus.rd_addr = rd_addr_reg;
  assign bus.tw_addr = tw_addr_reg;
  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
endmodule

// File: tb/tb_fft4_sequencer.sv
// tb_fft4_sequencer: scoreboard bench for fft4_sequencer with behavioural sample RAM and Q15 twiddle ROM.
// Expected address/twiddle traces and RAM results are queued before each transform starts.
module tb_fft4_sequencer;
  localparam int FW     = 32;
  localparam int LOG4_N = 2;
  localparam int AW     = 2 * LOG4_N;
  localparam int N      = 1 << AW;
  localparam int TOTAL  = 1 + 10 * LOG4_N * N / 4;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [AW-1:0] tw;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req;
  logic [FW-1:0] ram [N];
  logic [FW-1:0] img [N];
  logic [FW-1:0] rom [N];
  ev_t           rd_q[$];
  ev_t           wr_q[$];
  logic [FW-1:0] exp_ram_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  fft4_sequencer_if #(.FULL_WIDTH(FW), .AW(AW)) bus ();

  fft4_sequencer #(.FULL_WIDTH(FW), .LOG4_N(LOG4_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 1-cycle-latency RAM and ROM; load_req copies the staged image in one edge
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    bus.tw_data <= rom[bus.tw_addr];
    if (load_req) begin
      for (int i = 0; i < N; i++) ram[i] <= img[i];
    end else if (bus.wr_en) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  task automatic load_ram();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Fixed-point reference: Q15 products truncated, sums mod 2^16, DFT-4 via powers of -j.
  task automatic model_push();
    logic [FW-1:0] m [N];
    int xr[4], xi[4];
    int yr, yi, l, idx, e, ar, ai, wr, wi, p;
    logic signed [15:0] r16, i16;
    m = img;
    for (int s = 0; s < LOG4_N; s++) begin
      l = 1 << (2 * s);
      for (int g = 0; g < N / (4 * l); g++) begin
        for (int j = 0; j < l; j++) begin
          for (int k = 0; k < 4; k++) begin
            idx = g * 4 * l + j + k * l;
            e   = (j * k * (N / (4 * l))) % N;
            ar  = int'($signed(m[idx][31:16]));
            ai  = int'($signed(m[idx][15:0]));
            wr  = int'($signed(rom[e][31:16]));
            wi  = int'($signed(rom[e][15:0]));
            xr[k] = ((ar * wr) >>> 15) - ((ai * wi) >>> 15);
            xi[k] = ((ar * wi) >>> 15) + ((ai * wr) >>> 15);
          end
          for (int mo = 0; mo < 4; mo++) begin
            yr = 0;
            yi = 0;
            for (int n = 0; n < 4; n++) begin
              p = (n * mo) % 4;
              case (p)
                0: begin yr = yr + xr[n]; yi = yi + xi[n]; end
                1: begin yr = yr + xi[n]; yi = yi - xr[n]; end
                2: begin yr = yr - xr[n]; yi = yi - xi[n]; end
                default: begin yr = yr - xi[n]; yi = yi + xr[n]; end
              endcase
            end
            r16 = yr[15:0];
            i16 = yi[15:0];
`ifdef FFT_SCALE_EN
            r16 = r16 >>> 2;
            i16 = i16 >>> 2;
`endif
            m[g * 4 * l + j + mo * l] = {r16, i16};
          end
        end
      end
    end
    for (int i = 0; i < N; i++) exp_ram_q.push_back(m[i]);
  endtask

  // Starts one transform, scoreboards every strobe and, unless aborted, the final RAM image.
  task automatic run_transform(input string name, input bit inject, input int abort_at);
    ev_t ev;
    int  b, l;
    logic [FW-1:0] exp_w;
    rd_q.delete();
    wr_q.delete();
    b = 0;
    for (int s = 0; s < LOG4_N; s++) begin
      l = 1 << (2 * s);
      for (int g = 0; g < N / (4 * l); g++) begin
        for (int j = 0; j < l; j++) begin
          for (int k = 0; k < 4; k++) begin
            ev.addr = AW'(g * 4 * l + j + k * l);
            ev.tw   = AW'((j * k * (N / (4 * l))) % N);
            ev.cyc  = 1 + 10 * b + k;
            rd_q.push_back(ev);
            ev.cyc  = 7 + 10 * b + k;
            wr_q.push_back(ev);
          end
          b++;
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= TOTAL; c++) begin
      @(negedge clk);
      bus.start = inject && (c == 5 || c == 40);
      if (abort_at != 0 && c == abort_at + 1) begin
        checks++;
        if ({bus.busy, bus.rd_en, bus.wr_en, bus.done} !== 4'b0000) begin
          errors++;
          $display("FAIL %s reset_outputs cycle %0d: busy/rd_en/wr_en/done=%b required 0000",
                   name, c, {bus.busy, bus.rd_en, bus.wr_en, bus.done});
        end
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        $display("%s: aborted by reset at cycle %0d", name, abort_at);
        return;
      end
      checks++;
      if ({bus.busy, bus.done} !== {c < TOTAL, c == TOTAL}) begin
        errors++;
        $display("FAIL %s busy_done cycle %0d: got %b required %b", name, c,
                 {bus.busy, bus.done}, {c < TOTAL, c == TOTAL});
      end
      if (bus.rd_en === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s read cycle %0d: unexpected read addr %0d", name, c, bus.rd_addr);
        end else begin
          ev = rd_q.pop_front();
          if (c != ev.cyc || bus.rd_addr !== ev.addr || bus.tw_addr !== ev.tw) begin
            errors++;
            $display("FAIL %s read: got cycle %0d addr %0d tw %0d required cycle %0d addr %0d tw %0d",
                     name, c, bus.rd_addr, bus.tw_addr, ev.cyc, ev.addr, ev.tw);
          end
        end
      end
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL %s write cycle %0d: unexpected write addr %0d", name, c, bus.wr_addr);
        end else begin
          ev = wr_q.pop_front();
          if (c != ev.cyc || bus.wr_addr !== ev.addr) begin
            errors++;
            $display("FAIL %s write: got cycle %0d addr %0d required cycle %0d addr %0d",
                     name, c, bus.wr_addr, ev.cyc, ev.addr);
          end
        end
      end
      if (c == abort_at) rst = 1'b1;
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s trace_drain: %0d reads and %0d writes missing required 0 and 0",
               name, rd_q.size(), wr_q.size());
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      exp_w = (exp_ram_q.size() != 0) ? exp_ram_q.pop_front() : 'x;
      if (ram[i] !== exp_w) begin
        errors++;
        $display("FAIL %s ram[%0d]: got %h required %h", name, i, ram[i], exp_w);
      end
    end
    $display("%s: transform complete, done at cycle %0d", name, TOTAL);
  endtask

  task automatic stage_impulse();
    for (int i = 0; i < N; i++) img[i] = '0;
    img[0] = 32'h0100_0000;
    for (int i = 0; i < N; i++) begin
`ifdef FFT_SCALE_EN
      exp_ram_q.push_back(32'h000F_0000);
`else
      exp_ram_q.push_back(32'h00FE_0000);
`endif
    end
    load_ram();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset strobes: got %b required 0000", {bus.busy, bus.done, bus.rd_en, bus.wr_en});
    end
    checks++;
    if ({bus.rd_addr, bus.tw_addr, bus.wr_addr} !== '0) begin
      errors++;
      $display("FAIL reset addrs: got %h %h %h required 0 0 0", bus.rd_addr, bus.tw_addr, bus.wr_addr);
    end
    checks++;
    if (bus.wr_data !== '0) begin
      errors++;
      $display("FAIL reset wr_data: got %h required 0", bus.wr_data);
    end
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_impulse();
    stage_impulse();
    run_transform("impulse", 1'b0, 0);
  endtask

  task automatic test_dc();
    for (int i = 0; i < N; i++) begin
      img[i] = 32'h0100_0000;
`ifdef FFT_SCALE_EN
      exp_ram_q.push_back((i == 0) ? 32'h00FE_0000 : 32'h0);
`else
      exp_ram_q.push_back((i == 0) ? 32'h0FEC_0000 : 32'h0);
`endif
    end
    load_ram();
    run_transform("dc", 1'b0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) img[i] = $urandom;
      model_push();
      load_ram();
      run_transform("random", 1'b0, 0);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < N; i++) img[i] = {16'($urandom_range(0, 4095)), 16'($urandom_range(0, 4095))};
    model_push();
    load_ram();
    run_transform("start_while_busy", 1'b1, 0);
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < N; i++) img[i] = $urandom;
    load_ram();
    run_transform("reset_mid_op", 1'b0, 37);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.wr_en, bus.rd_en} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle: busy/wr_en/rd_en=%b required 000", {bus.busy, bus.wr_en, bus.rd_en});
      end
    end
    stage_impulse();
    run_transform("after_reset", 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    stage_impulse();
    run_transform("back_to_back_1", 1'b0, 0);
    stage_impulse();
    run_transform("back_to_back_2", 1'b0, 0);
  endtask

  initial begin
    rom = '{32'h7FFF_0000, 32'h7642_CF04, 32'h5A82_A57E, 32'h30FC_89BE,
            32'h0000_8001, 32'hCF04_89BE, 32'hA57E_A57E, 32'h89BE_CF04,
            32'h8001_0000, 32'h89BE_30FC, 32'hA57E_5A82, 32'hCF04_7642,
            32'h0000_7FFF, 32'h30FC_7642, 32'h5A82_5A82, 32'h7642_30FC};
    load_req = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_random();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft4_sequencer.md
# fft4_sequencer

In-place radix-4 decimation-in-time FFT controller. It sequences one internal `butterfly_4` instance (32-bit words: 16-bit real in the upper half, 16-bit imaginary in the lower half, Q15 twiddles) over an external sample RAM and twiddle ROM. It sits between the audio capture buffer and the magnitude/visualizer stage. Input samples must already be stored in base-4 digit-reversed order; results are left in natural order in the same RAM.

## Interface
Parameters:
- `FULL_WIDTH`, 32: word width; each half is one component.
- `LOG4_N`, 2: number of stages. N = 4^LOG4_N (16 by default). The address width `AW` is 2*LOG4_N.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  starts a transform; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE cycle (exclusive).
- `done`  out  1  one-cycle pulse when the transform is complete.
- `rd_en`  out  1  sample RAM read strobe.
- `rd_addr`  out  AW  sample RAM read address.
- `rd_data`  in  FULL_WIDTH  read data, valid exactly 1 cycle after `rd_en`.
- `tw_addr`  out  AW  twiddle ROM address (exponent e of W_N^e); read latency is 1 cycle.
- `tw_data`  in  FULL_WIDTH  twiddle word in Q15; e=0 returns 0x7FFF_0000.
- `wr_en`  out  1  sample RAM write strobe.
- `wr_addr`  out  AW  write address.
- `wr_data`  out  FULL_WIDTH  write data.

## Operation
- FSM states: IDLE, RD, RDW, BF, WR, DONE.
- **IDLE**
  - `start`=1 moves to RD with stage s=0, group g=0, index j=0.
  - `start` is ignored in every other state.
- **RD** (4 cycles, k=0..3)
  - `rd_en`=1.
  - `rd_addr` = base + k*L, where L = 4^s and base = g*4L + j.
  - `tw_addr` = (j*k) << 2*(LOG4_N-1-s), truncated to AW bits.
  - Data returned for operand k-1 is captured into operand register k-1 (a,b,c,d) and twiddle register k-1 (w0..w3).
- **RDW** (1 cycle): captures operand 3 and w3. No strobes are asserted.
- **BF** (1 cycle): the four butterfly outputs are registered into result registers r0..r3.
- **WR** (4 cycles, k=0..3)
  - `wr_en`=1, `wr_addr` = base + k*L, `wr_data` = r_k.
- **Advance** after WR k=3:
  - Increment j. When j wraps at L, reset j and increment g. When g wraps at N/(4L), reset g and increment s.
  - If s was the last stage, go to DONE; otherwise go to RD.
- **DONE** (1 cycle): `done`=1, `busy`=0, then IDLE.
- Reads for the next butterfly always follow the previous writes, so there is no RAW hazard and no bypass is needed.
- Butterfly arithmetic: 16x16 products, bits [30:15] kept (truncation), sums wrap modulo 2^16 with no saturation.
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Reset mid-transform: the next cycle has all strobes low and `busy`/`done`=0. No write is issued after the reset edge. RAM contents are undefined.

## Timing
- `start` is accepted at edge E0. RD begins in cycle 1.
- Each butterfly takes 10 cycles: RD 4, RDW 1, BF 1, WR 4.
- Total butterflies B = LOG4_N*N/4. `done` is high in cycle 1+10*B (cycle 81 for N=16). A new `start` is accepted in the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FFT_SCALE_EN` defined: each component of r0..r3 is arithmetically shifted right by 2 before writeback (1/4 per stage, total 1/N). This prevents overflow.
- `FFT_SCALE_EN` undefined: results are written unshifted. Overflow is the caller's responsibility.
- Cycle timing is identical in both builds.

## Test plan
- **Impulse:** N=16, RAM[0]=0x0100_0000, all others 0, unscaled → after `done`, all 16 words = 0x00FE_0000 (Q15 unity truncation loses 1 LSB per stage).
- **DC:** all 16 words 0x0100_0000, unscaled → RAM[0]=0x0FEC_0000, others 0. With `FFT_SCALE_EN` → RAM[0]=0x00FE_0000, others 0.
- **Address/twiddle trace:**
  - First butterfly reads addresses 0,1,2,3 with `tw_addr` 0,0,0,0.
  - Stage 1, j=1 reads 1,5,9,13 with `tw_addr` 0,1,2,3 and writes 1,5,9,13.
  - `done` appears in cycle 81 exactly.
- **Start while busy:** pulse `start` at cycles 5 and 40 → ignored. A single `done` appears at cycle 81 and the address trace is unchanged.
- **Reset mid-op:** assert `rst` at cycle 37 → cycle 38 has `busy`, `rd_en`, `wr_en` and `done` all 0 and the FSM is in IDLE. A new `start` then completes normally with `done` 80 cycles after its first RD cycle.
- **Back-to-back:** raise `start` in the cycle after `done` → the second transform is accepted immediately, and its impulse result matches the first scenario when the RAM is reloaded.
